// File: rtl/rs_issue_queue_pkg.sv
// Shared widths and entry layout for the parameterised reservation station.
package rs_issue_queue_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned ROB_W     = 4;
  localparam int unsigned PAYLOAD_W = 64;

  // One queue slot: tags, operand readiness and captured operand values
  typedef struct packed {
    logic [ROB_W-1:0]     rob;
    logic [PREG_W-1:0]    prd;
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic                 rdy1;
    logic                 rdy2;
    logic [XLEN-1:0]      data1;
    logic [XLEN-1:0]      data2;
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix plus oldest-first selection of up to ISSUE_W eligible entries.
module rs_age_select #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DISP_W  = 2,
  parameter int unsigned ISSUE_W = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DISP_W-1:0][DEPTH-1:0]     alloc_oh,
  input  logic [DEPTH-1:0]                 eligible,
  input  logic [ISSUE_W-1:0]               loadable,
  output logic [ISSUE_W-1:0][DEPTH-1:0]    gnt_oh_c,
  output logic [ISSUE_W-1:0]               gnt_valid_c
);

  // age_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0][DEPTH-1:0] age_q;
  logic [DEPTH-1:0][DEPTH-1:0] age_d;
  logic [DEPTH-1:0]            rem;
  logic [DEPTH-1:0]            oldest;

  // A new entry becomes younger than everything; lower ports are applied first
  always_comb begin
    age_d = age_q;
    for (int k = 0; k < int'(DISP_W); k++) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        if (alloc_oh[k][e]) begin
          for (int j = 0; j < int'(DEPTH); j++) begin
            age_d[e][j] = 1'b0;
            if (j != e) age_d[j][e] = 1'b1;
          end
        end
      end
    end
  end

  // Age matrix register
  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  // Repeatedly grant the oldest remaining eligible entry to the next loadable port
  always_comb begin
    rem         = eligible;
    oldest      = '0;
    gnt_oh_c    = '0;
    gnt_valid_c = '0;
    for (int p = 0; p < int'(ISSUE_W); p++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        oldest[i] = rem[i];
        for (int j = 0; j < int'(DEPTH); j++) begin
          if (j != i && rem[j] && !age_q[i][j]) oldest[i] = 1'b0;
        end
      end
      if (loadable[p] && (rem != '0)) begin
        gnt_oh_c[p]    = oldest;
        gnt_valid_c[p] = 1'b1;
        rem            = rem & ~oldest;
      end
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Parameterised out-of-order issue queue shared by the ALU and LSU pipes.
module rs_issue_queue
  import rs_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DISP_W    = 2,
  parameter int unsigned ISSUE_W   = 2,
  parameter int unsigned WB_W      = 3,
  parameter int unsigned XLEN      = rs_issue_queue_pkg::XLEN,
  parameter int unsigned PREG_W    = rs_issue_queue_pkg::PREG_W,
  parameter int unsigned ROB_W     = rs_issue_queue_pkg::ROB_W,
  parameter int unsigned PAYLOAD_W = rs_issue_queue_pkg::PAYLOAD_W,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [DISP_W-1:0]             disp_valid_i,
  output logic [DISP_W-1:0]             disp_ready_o,
  input  logic [DISP_W*ROB_W-1:0]       disp_rob_i,
  input  logic [DISP_W*PREG_W-1:0]      disp_prd_i,
  input  logic [DISP_W*PREG_W-1:0]      disp_prs1_i,
  input  logic [DISP_W*PREG_W-1:0]      disp_prs2_i,
  input  logic [DISP_W-1:0]             disp_rs1_rdy_i,
  input  logic [DISP_W-1:0]             disp_rs2_rdy_i,
  input  logic [DISP_W*XLEN-1:0]        disp_data1_i,
  input  logic [DISP_W*XLEN-1:0]        disp_data2_i,
  input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload_i,
  input  logic [WB_W-1:0]               wb_valid_i,
  input  logic [WB_W*PREG_W-1:0]        wb_prd_i,
  input  logic [WB_W*XLEN-1:0]          wb_data_i,
  output logic [ISSUE_W-1:0]            iss_valid_o,
  input  logic [ISSUE_W-1:0]            iss_ready_i,
  output logic [ISSUE_W*ROB_W-1:0]      iss_rob_o,
  output logic [ISSUE_W*PREG_W-1:0]     iss_prd_o,
  output logic [ISSUE_W*XLEN-1:0]       iss_data1_o,
  output logic [ISSUE_W*XLEN-1:0]       iss_data2_o,
  output logic [ISSUE_W*PAYLOAD_W-1:0]  iss_payload_o,
  output logic [CNT_W-1:0]              free_cnt_o
);

  logic [DEPTH-1:0]                  busy_q;
  rs_entry_t                         ent_q [DEPTH];
  rs_entry_t                         ent_d [DEPTH];
  logic                              kill;
  logic [DEPTH-1:0]                  avail;
  logic                              found;
  logic [DISP_W-1:0][DEPTH-1:0]      alloc_oh;
  logic [DEPTH-1:0]                  alloc_any;
  logic [CNT_W-1:0]                  acc_cnt;
  logic [DEPTH-1:0]                  eligible;
  logic [ISSUE_W-1:0]                loadable;
  logic [ISSUE_W-1:0][DEPTH-1:0]     gnt_oh;
  logic [ISSUE_W-1:0]                gnt_valid;
  logic [DEPTH-1:0]                  issued;
  logic [CNT_W-1:0]                  iss_cnt;
  logic [CNT_W-1:0]                  free_nxt;
  logic [DISP_W-1:0]                 ready_nxt;
  rs_entry_t                         iss_sel [ISSUE_W];

  // Reset behaves as a flush; both discard same-cycle dispatch and issue
  assign kill = rst | flush_i;

  // Accepted dispatch ports take free slots in ascending order (pre-issue view)
  always_comb begin
    avail     = ~busy_q;
    alloc_oh  = '0;
    alloc_any = '0;
    acc_cnt   = '0;
    found     = 1'b0;
    for (int k = 0; k < int'(DISP_W); k++) begin
      if (disp_valid_i[k] && disp_ready_o[k] && !kill) begin
        acc_cnt = acc_cnt + CNT_W'(1);
        found   = 1'b0;
        for (int e = 0; e < int'(DEPTH); e++) begin
          if (!found && avail[e]) begin
            alloc_oh[k][e] = 1'b1;
            avail[e]       = 1'b0;
            found          = 1'b1;
          end
        end
      end
      alloc_any = alloc_any | alloc_oh[k];
    end
  end

  // Wakeup of resident entries, then capture of new dispatches (lowest wb port wins)
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
      for (int w = int'(WB_W) - 1; w >= 0; w--) begin
        if (busy_q[i] && wb_valid_i[w]) begin
          if (!ent_q[i].rdy1 && (wb_prd_i[w*PREG_W +: PREG_W] == ent_q[i].prs1)) begin
            ent_d[i].rdy1  = 1'b1;
            ent_d[i].data1 = wb_data_i[w*XLEN +: XLEN];
          end
          if (!ent_q[i].rdy2 && (wb_prd_i[w*PREG_W +: PREG_W] == ent_q[i].prs2)) begin
            ent_d[i].rdy2  = 1'b1;
            ent_d[i].data2 = wb_data_i[w*XLEN +: XLEN];
          end
        end
      end
      for (int k = 0; k < int'(DISP_W); k++) begin
        if (alloc_oh[k][i]) begin
          ent_d[i].rob     = disp_rob_i[k*ROB_W +: ROB_W];
          ent_d[i].prd     = disp_prd_i[k*PREG_W +: PREG_W];
          ent_d[i].prs1    = disp_prs1_i[k*PREG_W +: PREG_W];
          ent_d[i].prs2    = disp_prs2_i[k*PREG_W +: PREG_W];
          ent_d[i].rdy1    = disp_rs1_rdy_i[k];
          ent_d[i].rdy2    = disp_rs2_rdy_i[k];
          ent_d[i].data1   = disp_data1_i[k*XLEN +: XLEN];
          ent_d[i].data2   = disp_data2_i[k*XLEN +: XLEN];
          ent_d[i].payload = disp_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
          for (int w = int'(WB_W) - 1; w >= 0; w--) begin
            if (wb_valid_i[w]) begin
              if (!disp_rs1_rdy_i[k] &&
                  (wb_prd_i[w*PREG_W +: PREG_W] == disp_prs1_i[k*PREG_W +: PREG_W])) begin
                ent_d[i].rdy1  = 1'b1;
                ent_d[i].data1 = wb_data_i[w*XLEN +: XLEN];
              end
              if (!disp_rs2_rdy_i[k] &&
                  (wb_prd_i[w*PREG_W +: PREG_W] == disp_prs2_i[k*PREG_W +: PREG_W])) begin
                ent_d[i].rdy2  = 1'b1;
                ent_d[i].data2 = wb_data_i[w*XLEN +: XLEN];
              end
            end
          end
        end
      end
    end
  end

  // Entry storage; contents are qualified by busy_q so no reset is needed
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Eligibility uses registered readiness only
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++)
      eligible[i] = busy_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
    for (int p = 0; p < int'(ISSUE_W); p++)
      loadable[p] = !kill && (!iss_valid_o[p] || iss_ready_i[p]);
  end

  rs_age_select #(
    .DEPTH   (DEPTH),
    .DISP_W  (DISP_W),
    .ISSUE_W (ISSUE_W)
  ) u_age_select (
    .clk         (clk),
    .rst         (rst),
    .alloc_oh    (alloc_oh),
    .eligible    (eligible),
    .loadable    (loadable),
    .gnt_oh_c    (gnt_oh),
    .gnt_valid_c (gnt_valid)
  );

  // Mux the granted entries and count what leaves the queue
  always_comb begin
    issued  = '0;
    iss_cnt = '0;
    for (int p = 0; p < int'(ISSUE_W); p++) begin
      iss_sel[p] = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (gnt_oh[p][i]) iss_sel[p] = ent_q[i];
      end
      if (gnt_valid[p]) begin
        issued  = issued | gnt_oh[p];
        iss_cnt = iss_cnt + CNT_W'(1);
      end
    end
  end

  // Next free count and the per-port ready it implies
  always_comb begin
    free_nxt = kill ? CNT_W'(DEPTH) : (free_cnt_o - acc_cnt + iss_cnt);
    for (int k = 0; k < int'(DISP_W); k++)
      ready_nxt[k] = (CNT_W'(k + 1) <= free_nxt);
  end

  // Occupancy, free count and dispatch ready
  always_ff @(posedge clk) begin
    if (kill) busy_q <= '0;
    else      busy_q <= (busy_q & ~issued) | alloc_any;
    free_cnt_o   <= free_nxt;
    disp_ready_o <= ready_nxt;
  end

  // Issue port valid: load on grant, drop on handshake
  always_ff @(posedge clk) begin
    if (kill) begin
      iss_valid_o <= '0;
    end else begin
      for (int p = 0; p < int'(ISSUE_W); p++) begin
        if (gnt_valid[p])        iss_valid_o[p] <= 1'b1;
        else if (iss_ready_i[p]) iss_valid_o[p] <= 1'b0;
      end
    end
  end

  // Issue port payload, held until the next load
  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(ISSUE_W); p++) begin
      if (gnt_valid[p]) begin
        iss_rob_o[p*ROB_W +: ROB_W]             <= iss_sel[p].rob;
        iss_prd_o[p*PREG_W +: PREG_W]           <= iss_sel[p].prd;
        iss_data1_o[p*XLEN +: XLEN]             <= iss_sel[p].data1;
        iss_data2_o[p*XLEN +: XLEN]             <= iss_sel[p].data2;
        iss_payload_o[p*PAYLOAD_W +: PAYLOAD_W] <= iss_sel[p].payload;
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue with hand-computed expectations.
module tb_rs_issue_queue;

  localparam int unsigned DEPTH = 8, DISP_W = 2, ISSUE_W = 2, WB_W = 3;
  localparam int unsigned XLEN = 64, PREG_W = 6, ROB_W = 4, PAYLOAD_W = 64;

  logic clk = 1'b0;
  logic rst, flush_i;
  logic [DISP_W-1:0]            disp_valid_i, disp_ready_o, disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic [DISP_W*ROB_W-1:0]      disp_rob_i;
  logic [DISP_W*PREG_W-1:0]     disp_prd_i, disp_prs1_i, disp_prs2_i;
  logic [DISP_W*XLEN-1:0]       disp_data1_i, disp_data2_i;
  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload_i;
  logic [WB_W-1:0]              wb_valid_i;
  logic [WB_W*PREG_W-1:0]       wb_prd_i;
  logic [WB_W*XLEN-1:0]         wb_data_i;
  logic [ISSUE_W-1:0]           iss_valid_o, iss_ready_i;
  logic [ISSUE_W*ROB_W-1:0]     iss_rob_o;
  logic [ISSUE_W*PREG_W-1:0]    iss_prd_o;
  logic [ISSUE_W*XLEN-1:0]      iss_data1_o, iss_data2_o;
  logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload_o;
  logic [3:0]                   free_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_issue_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_rob_i(disp_rob_i), .disp_prd_i(disp_prd_i),
    .disp_prs1_i(disp_prs1_i), .disp_prs2_i(disp_prs2_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
    .disp_data1_i(disp_data1_i), .disp_data2_i(disp_data2_i),
    .disp_payload_i(disp_payload_i),
    .wb_valid_i(wb_valid_i), .wb_prd_i(wb_prd_i), .wb_data_i(wb_data_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_rob_o(iss_rob_o), .iss_prd_o(iss_prd_o),
    .iss_data1_o(iss_data1_o), .iss_data2_o(iss_data2_o),
    .iss_payload_o(iss_payload_o), .free_cnt_o(free_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_valid_i = '0;
    wb_valid_i   = '0;
    flush_i      = 1'b0;
  endtask

  // Dispatch on port k; prd = rob + 40, payload tagged with rob
  task automatic disp(input int k, input logic [3:0] rob, input logic [5:0] prs1,
                      input logic [5:0] prs2, input logic r1, input logic r2,
                      input logic [63:0] d1, input logic [63:0] d2);
    disp_valid_i[k]          = 1'b1;
    disp_rob_i[k*4 +: 4]     = rob;
    disp_prd_i[k*6 +: 6]     = 6'(rob) + 6'd40;
    disp_prs1_i[k*6 +: 6]    = prs1;
    disp_prs2_i[k*6 +: 6]    = prs2;
    disp_rs1_rdy_i[k]        = r1;
    disp_rs2_rdy_i[k]        = r2;
    disp_data1_i[k*64 +: 64] = d1;
    disp_data2_i[k*64 +: 64] = d2;
    disp_payload_i[k*64 +: 64] = 64'hC0DE_0000 | 64'(rob);
  endtask

  task automatic wb(input int w, input logic [5:0] prd, input logic [63:0] d);
    wb_valid_i[w]         = 1'b1;
    wb_prd_i[w*6 +: 6]    = prd;
    wb_data_i[w*64 +: 64] = d;
  endtask

  function automatic logic [3:0] o_rob(input int p);
    return iss_rob_o[p*4 +: 4];
  endfunction
  function automatic logic [63:0] o_d1(input int p);
    return iss_data1_o[p*64 +: 64];
  endfunction
  function automatic logic [63:0] o_d2(input int p);
    return iss_data2_o[p*64 +: 64];
  endfunction

  initial begin
    rst = 1'b1; iss_ready_i = '0;
    disp_rob_i = '0; disp_prd_i = '0; disp_prs1_i = '0; disp_prs2_i = '0;
    disp_rs1_rdy_i = '0; disp_rs2_rdy_i = '0; disp_data1_i = '0; disp_data2_i = '0;
    disp_payload_i = '0; wb_prd_i = '0; wb_data_i = '0;
    idle();
    tick(); tick();
    chk("rst_free", 64'(free_cnt_o), 64'd8);
    chk("rst_valid", 64'(iss_valid_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 64'(disp_ready_o), 64'd3);

    // Two ready ops issue together, oldest to port 0
    iss_ready_i = 2'b11;
    disp(0, 4'd1, 6'd1, 6'd2, 1'b1, 1'b1, 64'h100, 64'h101);
    disp(1, 4'd2, 6'd3, 6'd4, 1'b1, 1'b1, 64'h200, 64'h201);
    tick(); idle();
    chk("a_free_after_disp", 64'(free_cnt_o), 64'd6);
    chk("a_valid_early", 64'(iss_valid_o), 64'd0);
    tick();
    chk("a_valid", 64'(iss_valid_o), 64'd3);
    chk("a_rob0", 64'(o_rob(0)), 64'd1);
    chk("a_rob1", 64'(o_rob(1)), 64'd2);
    chk("a_data1_p0", o_d1(0), 64'h100);
    chk("a_data2_p1", o_d2(1), 64'h201);
    chk("a_prd_p0", 64'(iss_prd_o[5:0]), 64'd41);
    chk("a_payload_p1", iss_payload_o[127:64], 64'hC0DE_0002);
    chk("a_free_back", 64'(free_cnt_o), 64'd8);
    tick();
    chk("a_drained", 64'(iss_valid_o), 64'd0);

    // Operand 1 woken two cycles after dispatch
    disp(0, 4'd3, 6'd5, 6'd6, 1'b0, 1'b1, 64'h0, 64'h22);
    tick(); idle();
    tick();
    chk("b_waiting", 64'(iss_valid_o), 64'd0);
    wb(0, 6'd9, 64'hDEAD);
    wb(1, 6'd5, 64'hABCD);
    tick(); idle();
    chk("b_no_early_issue", 64'(iss_valid_o), 64'd0);
    tick();
    chk("b_valid", 64'(iss_valid_o), 64'd1);
    chk("b_rob", 64'(o_rob(0)), 64'd3);
    chk("b_data1", o_d1(0), 64'hABCD);
    chk("b_data2", o_d2(0), 64'h22);
    tick();

    // Wakeup in the dispatch cycle
    disp(0, 4'd4, 6'd8, 6'd7, 1'b1, 1'b0, 64'h33, 64'h0);
    wb(2, 6'd7, 64'h11);
    tick(); idle();
    chk("c_not_yet", 64'(iss_valid_o), 64'd0);
    tick();
    chk("c_valid", 64'(iss_valid_o), 64'd1);
    chk("c_rob", 64'(o_rob(0)), 64'd4);
    chk("c_data1", o_d1(0), 64'h33);
    chk("c_data2", o_d2(0), 64'h11);
    tick();

    // Port-1-only dispatch; competing wakeups, lowest wb port wins
    disp(1, 4'd5, 6'd10, 6'd11, 1'b0, 1'b0, 64'h0, 64'h0);
    tick(); idle();
    wb(0, 6'd11, 64'hA0);
    wb(1, 6'd10, 64'hB1);
    wb(2, 6'd10, 64'hC2);
    tick(); idle();
    tick();
    chk("w_valid", 64'(iss_valid_o), 64'd1);
    chk("w_rob", 64'(o_rob(0)), 64'd5);
    chk("w_data1_lowest", o_d1(0), 64'hB1);
    chk("w_data2", o_d2(0), 64'hA0);
    tick();

    // Fill the queue under backpressure
    iss_ready_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      disp(0, 4'(8 + 2*i), 6'd1, 6'd1, 1'b1, 1'b1, 64'(16*(8 + 2*i)), 64'h0);
      disp(1, 4'(9 + 2*i), 6'd1, 6'd1, 1'b1, 1'b1, 64'(16*(9 + 2*i)), 64'h0);
      tick();
    end
    disp(0, 4'd0, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    disp(1, 4'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'h10, 64'h0);
    tick();
    chk("d_full_ready", 64'(disp_ready_o), 64'd0);
    chk("d_full_free", 64'(free_cnt_o), 64'd0);
    chk("d_full_valid", 64'(iss_valid_o), 64'd3);
    disp(0, 4'd2, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    disp(1, 4'd3, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("d_hold_valid", 64'(iss_valid_o), 64'd3);
      chk("d_hold_rob0", 64'(o_rob(0)), 64'd8);
      chk("d_hold_rob1", 64'(o_rob(1)), 64'd9);
      chk("d_hold_ready", 64'(disp_ready_o), 64'd0);
      chk("d_hold_free", 64'(free_cnt_o), 64'd0);
    end
    idle();
    iss_ready_i = 2'b01;
    tick();
    chk("d_p0_next", 64'(o_rob(0)), 64'd10);
    chk("d_p1_held", 64'(o_rob(1)), 64'd9);
    chk("d_ready_one", 64'(disp_ready_o), 64'd1);
    chk("d_free_one", 64'(free_cnt_o), 64'd1);
    iss_ready_i = 2'b11;
    tick();
    chk("d_rob0_11", 64'(o_rob(0)), 64'd11);
    chk("d_rob1_12", 64'(o_rob(1)), 64'd12);
    chk("d_data1_12", o_d1(1), 64'hC0);
    chk("d_free3", 64'(free_cnt_o), 64'd3);
    tick();
    chk("d_rob0_13", 64'(o_rob(0)), 64'd13);
    chk("d_rob1_14", 64'(o_rob(1)), 64'd14);
    tick();
    chk("d_rob0_15", 64'(o_rob(0)), 64'd15);
    chk("d_rob1_0", 64'(o_rob(1)), 64'd0);
    chk("d_free7", 64'(free_cnt_o), 64'd7);
    tick();
    chk("d_last_valid", 64'(iss_valid_o), 64'd1);
    chk("d_last_rob", 64'(o_rob(0)), 64'd1);
    chk("d_free8", 64'(free_cnt_o), 64'd8);
    tick();
    chk("d_empty", 64'(iss_valid_o), 64'd0);

    // Flush with five entries resident and one issue register valid
    iss_ready_i = 2'b00;
    disp(0, 4'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    disp(1, 4'd2, 6'd30, 6'd1, 1'b0, 1'b1, 64'h0, 64'h0);
    tick();
    disp(0, 4'd3, 6'd30, 6'd1, 1'b0, 1'b1, 64'h0, 64'h0);
    disp(1, 4'd4, 6'd30, 6'd1, 1'b0, 1'b1, 64'h0, 64'h0);
    tick();
    disp(0, 4'd5, 6'd30, 6'd1, 1'b0, 1'b1, 64'h0, 64'h0);
    disp(1, 4'd6, 6'd30, 6'd1, 1'b0, 1'b1, 64'h0, 64'h0);
    tick();
    chk("e_free3", 64'(free_cnt_o), 64'd3);
    chk("e_valid01", 64'(iss_valid_o), 64'd1);
    chk("e_rob1", 64'(o_rob(0)), 64'd1);
    disp(0, 4'd7, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    disp(1, 4'd8, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    flush_i = 1'b1;
    iss_ready_i = 2'b01;
    tick(); idle();
    chk("e_flush_valid", 64'(iss_valid_o), 64'd0);
    chk("e_flush_free", 64'(free_cnt_o), 64'd8);
    chk("e_flush_ready", 64'(disp_ready_o), 64'd3);
    iss_ready_i = 2'b11;
    wb(0, 6'd30, 64'h77);
    tick(); idle();
    chk("e_none_retained1", 64'(iss_valid_o), 64'd0);
    tick();
    chk("e_none_retained2", 64'(iss_valid_o), 64'd0);
    chk("e_free_still8", 64'(free_cnt_o), 64'd8);

    // Reset mid-operation wins over dispatch
    iss_ready_i = 2'b00;
    disp(0, 4'd9, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    tick(); idle();
    tick();
    chk("f_issued", 64'(iss_valid_o), 64'd1);
    disp(0, 4'd10, 6'd1, 6'd1, 1'b1, 1'b1, 64'h0, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    chk("f_rst_valid", 64'(iss_valid_o), 64'd0);
    chk("f_rst_free", 64'(free_cnt_o), 64'd8);
    tick();
    chk("f_rst_no_issue", 64'(iss_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_issue_queue.md
RS_ISSUE_QUEUE -- requirements
Module: rs_issue_queue

Interface
REQ-001 SHALL take parameters (name, default, meaning): DEPTH 8 entries; DISP_W 2 dispatch ports; ISSUE_W 2 issue ports; WB_W 3 wakeup ports; XLEN 64; PREG_W 6; ROB_W 4; PAYLOAD_W 64 opaque FU control bits (pc, imm, func3, selects).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 flush_i in 1 kills all entries and issue registers.
REQ-004 disp_valid_i in DISP_W per-port dispatch request; disp_ready_o out DISP_W per-port accept.
REQ-005 disp_rob_i in DISP_W*ROB_W; disp_prd_i, disp_prs1_i, disp_prs2_i in DISP_W*PREG_W; disp_rs1_rdy_i, disp_rs2_rdy_i in DISP_W; disp_data1_i, disp_data2_i in DISP_W*XLEN; disp_payload_i in DISP_W*PAYLOAD_W.
REQ-006 wb_valid_i in WB_W; wb_prd_i in WB_W*PREG_W; wb_data_i in WB_W*XLEN.
REQ-007 iss_valid_o out ISSUE_W; iss_ready_i in ISSUE_W FU accept; iss_rob_o, iss_prd_o, iss_data1_o, iss_data2_o, iss_payload_o out ISSUE_W-wide packed counterparts.
REQ-008 free_cnt_o out clog2(DEPTH+1) registered count of free entries.

Function
REQ-009 Dispatch port k SHALL be accepted iff disp_valid_i[k] and disp_ready_o[k]; disp_ready_o[k] high iff free entries >= k+1 (counted from the registered free vector), independent of disp_valid_i.
REQ-010 Accepted dispatches SHALL occupy distinct free entries, lowest free index to lowest port; entries freed this cycle are not reusable until next cycle.
REQ-011 An operand SHALL be captured ready at dispatch if its rdy input is set, or if any wb_valid_i[w] in the same cycle matches its prs; data taken from wb_data_i[w].
REQ-012 Each cycle every busy entry with unready operand matching a valid wakeup SHALL capture wb data and set ready; multiple matching wakeups: lowest w wins.
REQ-013 Entry eligible iff busy and both operands ready (registered state; same-cycle wakeup does not make an entry eligible).
REQ-014 Each issue port owns one output register; it can load when empty or when iss_valid_o & iss_ready_i this cycle.
REQ-015 Selection SHALL pick up to ISSUE_W eligible entries, oldest first by dispatch order (age matrix; wrap-free), filling loadable ports in ascending index; oldest goes to the lowest loadable port.
REQ-016 Within one dispatch cycle, port k entry is older than port k+1 entry.
REQ-017 Selected entry SHALL be freed and its fields copied to the port register the same edge; issue latency from eligibility to iss_valid_o = 1 cycle.
REQ-018 iss_valid_o with all iss_*_o SHALL hold stable until iss_ready_i; no entry issues twice.
REQ-019 flush_i SHALL, next edge, clear all busy bits and iss_valid_o, ignore same-cycle dispatch and issue, and force free_cnt_o = DEPTH.
REQ-020 Full queue: disp_ready_o all low; an entry issuing that cycle SHALL NOT raise disp_ready_o until the following cycle.
REQ-021 free_cnt_o SHALL update as prior - accepted dispatches + issued entries.

Reset
REQ-022 On rst: all busy bits 0, age matrix cleared, iss_valid_o 0, free_cnt_o DEPTH, disp_ready_o all high after reset deasserts; data/payload regs SHALL NOT require reset.
REQ-023 rst mid-operation SHALL behave as flush plus age clear; rst has priority over flush_i and dispatch.

Structure
REQ-024 A shared package SHALL hold XLEN, PREG_W, ROB_W defaults and an rs_entry_t struct (rob, prd, prs1/2, rdy1/2, data1/2, payload).
REQ-025 Oldest-first selection SHALL be one sub-module, rs_age_select (DEPTH-by-DEPTH age matrix, ISSUE_W grants); all else in rs_issue_queue.
REQ-026 rs_issue_queue SHALL replace the fixed-size ALU and LSU reservation stations by parameterisation.

Verification
REQ-027 Dispatch two ready ops (rob 1, 2) into empty queue, iss_ready_i=11 -> next cycle iss_valid_o=11, port0 rob 1, port1 rob 2; free_cnt_o back to 8.
REQ-028 Dispatch op prs1=5 unready; two cycles later wb_valid_i[1] prd 5 data 0xABCD -> iss_valid_o next cycle after capture, iss_data1_o=0xABCD.
REQ-029 Dispatch prs2=7 unready same cycle as wb prd 7 data 0x11 -> entry ready at dispatch, issues following cycle with data2 0x11.
REQ-030 Fill 8 entries -> disp_ready_o=00; hold iss_ready_i=00 three cycles -> outputs stable; raise iss_ready_i[0] -> next oldest loads, disp_ready_o[0] high a cycle later.
REQ-031 Queue holding 5 entries, 1 valid issue reg, assert flush_i with disp_valid_i=11 -> next cycle iss_valid_o=00, free_cnt_o=8, no entry retained.
REQ-032 Random dispatch/wakeup/backpressure 10k cycles vs scoreboard -> each rob issued exactly once, oldest-first among eligible, correct operand data.
